// File: rtl/dot_char_loader_if.sv
// dot_char_loader_if
//   Bundles the request handshake and the DotController-facing column bus of
//   dot_char_loader.
//   Request side : char_code[4:0], char_pos[2:0], char_valid, char_ready
//   System side  : disp_enable (display enable request)
//   Display side : colAddr[4:0], rowIn[6:0], write, enable
//   Status       : done, err (one-cycle pulses at request completion)
//   master = requester/system side, slave = dot_char_loader itself.
interface dot_char_loader_if;
   logic [4:0] char_code;
   logic [2:0] char_pos;
   logic       char_valid;
   logic       char_ready;
   logic       disp_enable;
   logic [4:0] colAddr;
   logic [6:0] rowIn;
   logic       write;
   logic       enable;
   logic       done;
   logic       err;

   modport master (
      output char_code, char_pos, char_valid, disp_enable,
      input  char_ready, colAddr, rowIn, write, enable, done, err
   );

   modport slave (
      input  char_code, char_pos, char_valid, disp_enable,
      output char_ready, colAddr, rowIn, write, enable, done, err
   );
endinterface

// File: rtl/dot_char_loader.sv
// dot_char_loader
//   Accepts one character code (hex 0-F, codes >= 16 draw a blank) and a cell
//   position over a valid/ready handshake, looks the glyph up in a 5x7 font
//   ROM and plays its five columns onto DotController's colAddr/rowIn/write
//   inputs, each column held for HOLD_CYCLES clocks. enable is disp_enable
//   delayed by one clock. done pulses when a request finishes; err pulses
//   with done when the requested cell is beyond NUM_CHARS (nothing written).
//   Ports:
//     clk   - system clock, rising edge
//     reset - asynchronous, active-high
//     bus   - dot_char_loader_if.slave (request, display bus, status)
//   All outputs are registered.
module dot_char_loader #(
   parameter int NUM_CHARS   = 1,   // 1..6 character cells
   parameter int HOLD_CYCLES = 1    // 1..15 clocks per column
) (
   input logic           clk,
   input logic           reset,
   dot_char_loader_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;

   localparam logic [3:0] NUM_CHARS_W = 4'(NUM_CHARS);
   localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);

   state_t     state_reg, state_next;
   logic [4:0] code_reg, code_next;
   logic [2:0] pos_reg, pos_next;
   logic [2:0] col_reg, col_next;
   logic [3:0] hold_reg, hold_next;
   logic       ready_reg, ready_next;
   logic [4:0] col_addr_reg, col_addr_next;
   logic [6:0] row_reg, row_next;
   logic       write_reg, write_next;
   logic       done_reg, done_next;
   logic       err_reg, err_next;
   logic       enable_reg;

   // Font ROM, column-major, bit0 = top row. Codes 16..31 are blank.
   function automatic logic [6:0] font_col(input logic [4:0] code, input logic [2:0] col);
      logic [34:0] glyph;
      logic [6:0]  column;
      case (code)
         5'd0:    glyph = {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
         5'd1:    glyph = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
         5'd2:    glyph = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
         5'd3:    glyph = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
         5'd4:    glyph = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
         5'd5:    glyph = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
         5'd6:    glyph = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
         5'd7:    glyph = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
         5'd8:    glyph = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
         5'd9:    glyph = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
         5'd10:   glyph = {7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E};
         5'd11:   glyph = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h36};
         5'd12:   glyph = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h22};
         5'd13:   glyph = {7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C};
         5'd14:   glyph = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
         5'd15:   glyph = {7'h7F, 7'h09, 7'h09, 7'h09, 7'h01};
         default: glyph = 35'd0;
      endcase
      case (col)
         3'd0:    column = glyph[34:28];
         3'd1:    column = glyph[27:21];
         3'd2:    column = glyph[20:14];
         3'd3:    column = glyph[13:7];
         default: column = glyph[6:0];
      endcase
      return column;
   endfunction

   // Base column of a cell; only used for in-range cells, so 5 bits suffice.
   function automatic logic [4:0] col_addr_of(input logic [2:0] pos, input logic [2:0] col);
      return ({2'b00, pos} * 5'd5) + {2'b00, col};
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         code_reg     <= 5'd0;
         pos_reg      <= 3'd0;
         col_reg      <= 3'd0;
         hold_reg     <= 4'd0;
         ready_reg    <= 1'b0;
         col_addr_reg <= 5'd0;
         row_reg      <= 7'd0;
         write_reg    <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         enable_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         code_reg     <= code_next;
         pos_reg      <= pos_next;
         col_reg      <= col_next;
         hold_reg     <= hold_next;
         ready_reg    <= ready_next;
         col_addr_reg <= col_addr_next;
         row_reg      <= row_next;
         write_reg    <= write_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         enable_reg   <= bus.disp_enable;
      end
   end

   // Outputs are registered, so this block computes the output values for the
   // state being entered: the accept edge already loads column 0.
   always_comb begin
      state_next    = state_reg;
      code_next     = code_reg;
      pos_next      = pos_reg;
      col_next      = col_reg;
      hold_next     = hold_reg;
      ready_next    = 1'b0;
      col_addr_next = col_addr_reg;
      row_next      = row_reg;
      write_next    = 1'b0;
      done_next     = 1'b0;
      err_next      = 1'b0;

      case (state_reg)
         IDLE: begin
            ready_next = 1'b1;
            if (bus.char_valid && ready_reg) begin
               code_next  = bus.char_code;
               pos_next   = bus.char_pos;
               ready_next = 1'b0;
               if ({1'b0, bus.char_pos} >= NUM_CHARS_W) begin
                  state_next = FIN;
                  done_next  = 1'b1;
                  err_next   = 1'b1;
               end else begin
                  state_next    = WRITE;
                  col_next      = 3'd0;
                  hold_next     = 4'd0;
                  write_next    = 1'b1;
                  col_addr_next = col_addr_of(bus.char_pos, 3'd0);
                  row_next      = font_col(bus.char_code, 3'd0);
               end
            end
         end

         WRITE: begin
            write_next = 1'b1;
            if (hold_reg == HOLD_LAST) begin
               if (col_reg == 3'd4) begin
                  // Last column done; colAddr/rowIn keep their last values.
                  state_next = FIN;
                  write_next = 1'b0;
                  done_next  = 1'b1;
               end else begin
                  col_next      = col_reg + 3'd1;
                  hold_next     = 4'd0;
                  col_addr_next = col_addr_of(pos_reg, col_reg + 3'd1);
                  row_next      = font_col(code_reg, col_reg + 3'd1);
               end
            end else begin
               hold_next = hold_reg + 4'd1;
            end
         end

         FIN: begin
            state_next = IDLE;
            ready_next = 1'b1;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.char_ready = ready_reg;
   assign bus.colAddr    = col_addr_reg;
   assign bus.rowIn      = row_reg;
   assign bus.write      = write_reg;
   assign bus.enable     = enable_reg;
   assign bus.done       = done_reg;
   assign bus.err        = err_reg;

endmodule

// File: tb/tb_dot_char_loader.sv
// Bench for dot_char_loader. Two instances share clk/reset:
//   dut_a: NUM_CHARS=2, HOLD_CYCLES=1
//   dut_b: NUM_CHARS=4, HOLD_CYCLES=3
// Outputs are sampled on the falling edge, inputs driven on the falling edge.
// Compared vector: {char_ready, write, colAddr, rowIn, done, err, enable}.
module tb_dot_char_loader;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dot_char_loader_if if_a ();
   dot_char_loader_if if_b ();

   dot_char_loader #(.NUM_CHARS(2), .HOLD_CYCLES(1)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (if_a.slave)
   );

   dot_char_loader #(.NUM_CHARS(4), .HOLD_CYCLES(3)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (if_b.slave)
   );

   int total = 0;
   int bad   = 0;

   logic [16:0] obs_a, obs_b;
   assign obs_a = {if_a.char_ready, if_a.write, if_a.colAddr, if_a.rowIn, if_a.done, if_a.err, if_a.enable};
   assign obs_b = {if_b.char_ready, if_b.write, if_b.colAddr, if_b.rowIn, if_b.done, if_b.err, if_b.enable};

   task automatic send_a(input logic [4:0] code, input logic [2:0] pos);
      @(negedge clk);
      if_a.char_code  = code;
      if_a.char_pos   = pos;
      if_a.char_valid = 1'b1;
      @(negedge clk);
      if_a.char_valid = 1'b0;
   endtask

   task automatic send_b(input logic [4:0] code, input logic [2:0] pos);
      @(negedge clk);
      if_b.char_code  = code;
      if_b.char_pos   = pos;
      if_b.char_valid = 1'b1;
      @(negedge clk);
      if_b.char_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [16:0] want;
      reset = 1'b1;
      if_a.char_code = 5'd0; if_a.char_pos = 3'd0; if_a.char_valid = 1'b0; if_a.disp_enable = 1'b1;
      if_b.char_code = 5'd0; if_b.char_pos = 3'd0; if_b.char_valid = 1'b0; if_b.disp_enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      want = 17'd0;
      total++;
      if (obs_a !== want) begin bad++; $display("FAIL reset_a got=%h want=%h", obs_a, want); end
      total++;
      if (obs_b !== want) begin bad++; $display("FAIL reset_b got=%h want=%h", obs_b, want); end
      reset = 1'b0;
      @(negedge clk);
      want = {1'b1, 1'b0, 5'd0, 7'h00, 1'b0, 1'b0, 1'b1};
      total++;
      if (obs_a !== want) begin bad++; $display("FAIL release_a got=%h want=%h", obs_a, want); end
      total++;
      if (obs_b !== want) begin bad++; $display("FAIL release_b got=%h want=%h", obs_b, want); end
   endtask

   // pos 3 and pos 2 are both out of range for NUM_CHARS=2.
   task automatic test_pos_error();
      logic [16:0] want;
      logic [2:0]  bad_pos [0:1];
      bad_pos = '{3'd3, 3'd2};
      for (int t = 0; t < 2; t++) begin
         send_a(5'd8, bad_pos[t]);
         want = {1'b0, 1'b0, 5'd0, 7'h00, 1'b1, 1'b1, 1'b1};
         total++;
         if (obs_a !== want) begin bad++; $display("FAIL pos_err%0d_done got=%h want=%h", bad_pos[t], obs_a, want); end
         @(negedge clk);
         want = {1'b1, 1'b0, 5'd0, 7'h00, 1'b0, 1'b0, 1'b1};
         total++;
         if (obs_a !== want) begin bad++; $display("FAIL pos_err%0d_idle got=%h want=%h", bad_pos[t], obs_a, want); end
      end
   endtask

   // Last legal cell (pos 1) writes glyph 8 at columns 5..9.
   task automatic test_pos_boundary();
      logic [16:0] want;
      logic [6:0]  exp_rows [0:4];
      exp_rows = '{7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
      send_a(5'd8, 3'd1);
      for (int k = 1; k <= 5; k++) begin
         want = {1'b0, 1'b1, 5'(4 + k), exp_rows[k-1], 1'b0, 1'b0, 1'b1};
         total++;
         if (obs_a !== want) begin bad++; $display("FAIL pos1_col%0d got=%h want=%h", k - 1, obs_a, want); end
         @(negedge clk);
      end
      want = {1'b0, 1'b0, 5'd9, 7'h36, 1'b1, 1'b0, 1'b1};
      total++;
      if (obs_a !== want) begin bad++; $display("FAIL pos1_done got=%h want=%h", obs_a, want); end
      @(negedge clk);
   endtask

   task automatic test_glyph_one();
      logic [16:0] want;
      logic [6:0]  exp_rows [0:4];
      exp_rows = '{7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
      send_a(5'd1, 3'd0);
      for (int k = 1; k <= 5; k++) begin
         want = {1'b0, 1'b1, 5'(k - 1), exp_rows[k-1], 1'b0, 1'b0, 1'b1};
         total++;
         if (obs_a !== want) begin bad++; $display("FAIL one_col%0d got=%h want=%h", k - 1, obs_a, want); end
         @(negedge clk);
      end
      want = {1'b0, 1'b0, 5'd4, 7'h00, 1'b1, 1'b0, 1'b1};
      total++;
      if (obs_a !== want) begin bad++; $display("FAIL one_done got=%h want=%h", obs_a, want); end
      @(negedge clk);
      want = {1'b1, 1'b0, 5'd4, 7'h00, 1'b0, 1'b0, 1'b1};
      total++;
      if (obs_a !== want) begin bad++; $display("FAIL one_ready got=%h want=%h", obs_a, want); end
   endtask

   task automatic test_hold3();
      logic [16:0] want;
      logic [6:0]  exp_rows [0:4];
      int          col;
      exp_rows = '{7'h7E, 7'h11, 7'h11, 7'h11, 7'h7E};
      send_b(5'd10, 3'd2);
      for (int k = 1; k <= 15; k++) begin
         col  = (k - 1) / 3;
         want = {1'b0, 1'b1, 5'(10 + col), exp_rows[col], 1'b0, 1'b0, 1'b1};
         total++;
         if (obs_b !== want) begin bad++; $display("FAIL hold3_cyc%0d got=%h want=%h", k, obs_b, want); end
         @(negedge clk);
      end
      want = {1'b0, 1'b0, 5'd14, 7'h7E, 1'b1, 1'b0, 1'b1};
      total++;
      if (obs_b !== want) begin bad++; $display("FAIL hold3_done got=%h want=%h", obs_b, want); end
      @(negedge clk);
      want = {1'b1, 1'b0, 5'd14, 7'h7E, 1'b0, 1'b0, 1'b1};
      total++;
      if (obs_b !== want) begin bad++; $display("FAIL hold3_ready got=%h want=%h", obs_b, want); end
   endtask

   // Blank glyph; a request for F arrives while busy and must be dropped.
   task automatic test_blank_busy();
      logic [16:0] want;
      send_a(5'd20, 3'd0);
      for (int k = 1; k <= 5; k++) begin
         want = {1'b0, 1'b1, 5'(k - 1), 7'h00, 1'b0, 1'b0, 1'b1};
         total++;
         if (obs_a !== want) begin bad++; $display("FAIL blank_col%0d got=%h want=%h", k - 1, obs_a, want); end
         if (k == 2) begin
            if_a.char_code  = 5'd15;
            if_a.char_valid = 1'b1;
         end
         if (k == 3) if_a.char_valid = 1'b0;
         @(negedge clk);
      end
      want = {1'b0, 1'b0, 5'd4, 7'h00, 1'b1, 1'b0, 1'b1};
      total++;
      if (obs_a !== want) begin bad++; $display("FAIL blank_done got=%h want=%h", obs_a, want); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         want = {1'b1, 1'b0, 5'd4, 7'h00, 1'b0, 1'b0, 1'b1};
         total++;
         if (obs_a !== want) begin bad++; $display("FAIL busy_ignored%0d got=%h want=%h", k, obs_a, want); end
      end
   endtask

   task automatic test_reset_mid();
      logic [16:0] want;
      logic [6:0]  exp8 [0:4];
      logic [6:0]  exp0 [0:4];
      exp8 = '{7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
      exp0 = '{7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
      send_a(5'd8, 3'd0);
      for (int k = 1; k <= 3; k++) begin
         want = {1'b0, 1'b1, 5'(k - 1), exp8[k-1], 1'b0, 1'b0, 1'b1};
         total++;
         if (obs_a !== want) begin bad++; $display("FAIL mid_col%0d got=%h want=%h", k - 1, obs_a, want); end
         if (k < 3) @(negedge clk);
      end
      #2 reset = 1'b1;
      #1;
      want = 17'd0;
      total++;
      if (obs_a !== want) begin bad++; $display("FAIL async_clear got=%h want=%h", obs_a, want); end
      @(negedge clk);
      total++;
      if (obs_a !== want) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs_a, want); end
      reset = 1'b0;
      @(negedge clk);
      want = {1'b1, 1'b0, 5'd0, 7'h00, 1'b0, 1'b0, 1'b1};
      total++;
      if (obs_a !== want) begin bad++; $display("FAIL post_reset got=%h want=%h", obs_a, want); end
      send_a(5'd0, 3'd0);
      for (int k = 1; k <= 5; k++) begin
         want = {1'b0, 1'b1, 5'(k - 1), exp0[k-1], 1'b0, 1'b0, 1'b1};
         total++;
         if (obs_a !== want) begin bad++; $display("FAIL zero_col%0d got=%h want=%h", k - 1, obs_a, want); end
         @(negedge clk);
      end
      want = {1'b0, 1'b0, 5'd4, 7'h3E, 1'b1, 1'b0, 1'b1};
      total++;
      if (obs_a !== want) begin bad++; $display("FAIL zero_done got=%h want=%h", obs_a, want); end
      @(negedge clk);
   endtask

   // disp_enable drops after cycle 1 and returns after cycle 3.
   task automatic test_enable_toggle();
      logic [16:0] want;
      logic [6:0]  exp_rows [0:4];
      logic        exp_en   [0:4];
      exp_rows = '{7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
      exp_en   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      send_a(5'd1, 3'd0);
      for (int k = 1; k <= 5; k++) begin
         want = {1'b0, 1'b1, 5'(k - 1), exp_rows[k-1], 1'b0, 1'b0, exp_en[k-1]};
         total++;
         if (obs_a !== want) begin bad++; $display("FAIL en_col%0d got=%h want=%h", k - 1, obs_a, want); end
         if (k == 1) if_a.disp_enable = 1'b0;
         if (k == 3) if_a.disp_enable = 1'b1;
         @(negedge clk);
      end
      want = {1'b0, 1'b0, 5'd4, 7'h00, 1'b1, 1'b0, 1'b1};
      total++;
      if (obs_a !== want) begin bad++; $display("FAIL en_done got=%h want=%h", obs_a, want); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_pos_error();
      test_pos_boundary();
      test_glyph_one();
      test_hold3();
      test_blank_busy();
      test_reset_mid();
      test_enable_toggle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
